// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: parity modes, FSM state encodings,
// oversampling constants and the parity-bit helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 8;

  // Parity bit that completes the frame, given the XOR of the data bits.
  function automatic logic parity_bit(input logic xor_data, input parity_e par);
    return (par == PAR_ODD) ? ~xor_data : xor_data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator; ticks once every baud_div_i+1 clocks and
// reloads the divider at each wrap so a new rate takes effect on the next period.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);
  assign cnt_d  = tick_o ? baud_div_i : cnt_q - DIV_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with independent TX and RX FSMs sharing one 16x tick generator.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter parity_e     PARITY    = PAR_NONE,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 uart_tx_o,
  output logic                 tx_done_o,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o
);

  localparam int unsigned    BcW      = $clog2(DATA_BITS);
  localparam logic [BcW-1:0] BitLast  = BcW'(DATA_BITS - 1);
  localparam logic [BcW-1:0] StopLast = BcW'(STOP_BITS - 1);
  localparam logic [3:0]     TickLast = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]     TickMid  = 4'(SAMPLE_POINT - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_core: illegal PARITY");
  end

  logic tick;

  uart_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .baud_div_i(baud_div_i),
    .tick_o    (tick)
  );

  // ---------------- Transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [BcW-1:0]       tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_started_q, tx_started_d;
  logic                 tx_par_q;
  logic                 tx_bit_end;

  // ---------------- Receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [BcW-1:0]       rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_fall, rx_bit_end;

`ifdef UART_PARITY_EN
  localparam bit HasParity = (PARITY != PAR_NONE);
  logic rx_par_q, rx_perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_par_q  <= 1'b0;
      rx_par_q  <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      if (tx_state_q == TxIdle && tx_valid_i) begin
        tx_par_q <= parity_bit(^tx_data_i, PARITY);
      end
      if (rx_state_q == RxParity && rx_bit_end) begin
        rx_par_q <= rx_sync_q;
      end
      if (rx_state_q == RxStop && rx_bit_end) begin
        rx_perr_q <= HasParity && (rx_par_q != parity_bit(^rx_shreg_q, PARITY));
      end
    end
  end

  assign rx_parity_err_o = rx_perr_q;
`else
  localparam bit HasParity = 1'b0;
  assign tx_par_q        = 1'b0;
  assign rx_parity_err_o = 1'b0;
`endif

  assign tx_bit_end = tick && (tx_tcnt_q == TickLast);

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_tcnt_d    = tx_tcnt_q;
    tx_bcnt_d    = tx_bcnt_q;
    tx_shreg_d   = tx_shreg_q;
    tx_line_d    = tx_line_q;
    tx_started_d = tx_started_q;
    tx_done_o    = 1'b0;
    if (tx_started_q && tick && !tx_bit_end) begin
      tx_tcnt_d = tx_tcnt_q + 4'd1;
    end
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_valid_i) begin
          tx_shreg_d = tx_data_i;
          tx_tcnt_d  = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        // Accepted words wait for the next tick so every bit spans exactly 16 ticks.
        if (tick && !tx_started_q) begin
          tx_line_d    = 1'b0;
          tx_started_d = 1'b1;
        end else if (tx_bit_end) begin
          tx_line_d  = tx_shreg_q[0];
          tx_shreg_d = tx_shreg_q >> 1;
          tx_bcnt_d  = '0;
          tx_tcnt_d  = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_tcnt_d = '0;
          if (tx_bcnt_q == BitLast) begin
            tx_bcnt_d = '0;
            if (HasParity) begin
              tx_line_d  = tx_par_q;
              tx_state_d = TxParity;
            end else begin
              tx_line_d  = 1'b1;
              tx_state_d = TxStop;
            end
          end else begin
            tx_line_d  = tx_shreg_q[0];
            tx_shreg_d = tx_shreg_q >> 1;
            tx_bcnt_d  = tx_bcnt_q + BcW'(1);
          end
        end
      end
      TxParity: begin
        if (tx_bit_end) begin
          tx_line_d  = 1'b1;
          tx_tcnt_d  = '0;
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_tcnt_d = '0;
          if (tx_bcnt_q == StopLast) begin
            tx_done_o    = 1'b1;
            tx_started_d = 1'b0;
            tx_state_d   = TxIdle;
          end else begin
            tx_bcnt_d = tx_bcnt_q + BcW'(1);
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q   <= TxIdle;
      tx_tcnt_q    <= '0;
      tx_bcnt_q    <= '0;
      tx_shreg_q   <= '0;
      tx_line_q    <= 1'b1;
      tx_started_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_tcnt_q    <= tx_tcnt_d;
      tx_bcnt_q    <= tx_bcnt_d;
      tx_shreg_q   <= tx_shreg_d;
      tx_line_q    <= tx_line_d;
      tx_started_q <= tx_started_d;
    end
  end

  assign tx_ready_o = (tx_state_q == TxIdle);
  assign uart_tx_o  = tx_line_q;

  assign rx_fall    = rx_prev_q && !rx_sync_q;
  assign rx_bit_end = tick && (rx_tcnt_q == TickLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
    if (rx_state_q != RxIdle && tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_tcnt_d  = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        // Mid-start check; from here each full 16-tick period lands mid-bit.
        if (tick && rx_tcnt_q == TickMid) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_tcnt_d  = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_bcnt_q == BitLast) begin
            rx_state_d = HasParity ? RxParity : RxStop;
          end else begin
            rx_bcnt_d = rx_bcnt_q + BcW'(1);
          end
        end
      end
      RxParity: begin
        if (rx_bit_end) begin
          rx_tcnt_d  = '0;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_bit_end) begin
          rx_tcnt_d  = '0;
          rx_data_d  = rx_shreg_q;
          rx_ferr_d  = !rx_sync_q;
          rx_valid_d = 1'b1;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_ferr_q;

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, SHALL set TX stop bits; legal values 1 or 2.
REQ-003 Parameter PARITY, default PAR_NONE, SHALL select parity: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter DIV_W, default 16, SHALL set the width of baud_div.
REQ-005 Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-006 Port clk  in  1  sole clock; all state on rising edge.
REQ-007 Port rst  in  1  asynchronous active-high reset.
REQ-008 Port baud_div  in  DIV_W  16x-oversample tick period minus 1, in clk cycles.
REQ-009 Port tx_data  in  DATA_BITS  byte to transmit.
REQ-010 Port tx_valid  in  1  transmit request.
REQ-011 Port tx_ready  out  1  transmitter idle, can accept.
REQ-012 Port uart_tx  out  1  serial output, idle high.
REQ-013 Port tx_done  out  1  one-cycle pulse at end of last stop bit.
REQ-014 Port uart_rx  in  1  asynchronous serial input.
REQ-015 Port rx_data  out  DATA_BITS  last received word, held until next.
REQ-016 Port rx_valid  out  1  one-cycle pulse, new word on rx_data.
REQ-017 Port rx_frame_err / rx_parity_err  out  1 each  qualified by rx_valid.

Function
REQ-018 Tick generator SHALL free-run, emitting one tick every baud_div+1 clks, reloading baud_div at each wrap; baud_div=0 ticks every clk.
REQ-019 One bit period SHALL be 16 ticks for both TX and RX.
REQ-020 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PAR_NONE.
REQ-021 tx_ready SHALL be 1 only in IDLE; transfer occurs on clk with tx_valid&&tx_ready; tx_data is captured then.
REQ-022 uart_tx SHALL go low at the first tick after acceptance; data sent LSB first; TX bit periods aligned to ticks.
REQ-023 Even parity bit SHALL make the count of ones (data+parity) even; odd makes it odd.
REQ-024 After STOP_BITS stop bits, tx_done SHALL pulse one cycle and FSM returns IDLE; tx_valid while busy is ignored.
REQ-025 uart_rx SHALL pass a 2-flop synchroniser; RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-026 Falling edge in IDLE SHALL enter START; if line is high at tick 8, return IDLE with no output (glitch reject).
REQ-027 Data, parity and stop SHALL be sampled at tick 8 of their bit period.
REQ-028 At first stop-bit sample: rx_data updated, rx_valid pulses, rx_frame_err=~stop, rx_parity_err=mismatch; FSM returns IDLE (second stop bit not checked).
REQ-029 Frame with frame error SHALL still update rx_data and pulse rx_valid.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 On rst: uart_tx=1, tx_ready=1, tx_done=0, rx_data=0, rx_valid=0, both errors 0, FSMs IDLE, counters 0, synchroniser flops 1.
REQ-032 rst mid-frame SHALL abort both frames immediately; no tx_done/rx_valid for the aborted frame.

Configuration
REQ-033 Macro UART_PARITY_EN defined: PARITY honoured as above.
REQ-034 Macro UART_PARITY_EN undefined: no parity logic, PARITY ignored, frames have no parity bit, rx_parity_err tied 0.

Structure
REQ-035 Package uart_pkg SHALL hold parity_e (PAR_NONE/EVEN/ODD), tx/rx state enums, OVERSAMPLE=16, SAMPLE_POINT=8.
REQ-036 Tick generator SHALL be sub-module uart_baud_gen, shared by TX and RX.

Verification (DATA_BITS=8, STOP_BITS=1, baud_div=3 -> 64 clk/bit)
REQ-037 PAR_NONE, send 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1 each 64 clk; tx_done ~640 clk after accept; tx_ready low meanwhile.
REQ-038 Loopback uart_tx->uart_rx, send 0x3C -> rx_valid once, rx_data=0x3C, both errors 0.
REQ-039 PAR_EVEN with UART_PARITY_EN, send 0x07 -> parity bit 1; inject flipped parity on RX -> rx_parity_err=1 with rx_valid.
REQ-040 Drive uart_rx low 20 clk then high -> no rx_valid; next valid frame 0x55 received correctly.
REQ-041 RX frame 0x81 with stop bit forced 0 -> rx_valid, rx_data=0x81, rx_frame_err=1.
REQ-042 Assert rst during TX data bit 3 -> uart_tx=1 same cycle, tx_ready=1, no tx_done; next send 0xFF correct.
